// File: rtl/adc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_pkg                                                              |
// | Shared state encoding and frame constants for the MCP3x08 scanner.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package adc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } scan_state_t;

    localparam int CMD_CLKS  = 5;
    localparam int NULL_CLKS = 1;

    // SCLK periods in one conversion frame for a converter of the given width
    function automatic int frame_clks(input int bits);
        return CMD_CLKS + NULL_CLKS + bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sclk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_sclk_gen                                                         |
// | Half-period divider with tick/rise/fall strobes and a mode-0 SCLK.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module adc_sclk_gen #(
    parameter int CLK_DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic shift_en,
    output logic tick,
    output logic rise,
    output logic fall,
    output logic sclk
);

    localparam int              c_CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(CLK_DIV - 1);

    logic [c_CW-1:0] r_cnt;
    logic            r_sclk;

    // Counter is held at zero while stopped so every run starts with a full half-period
    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = run && (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || !shift_en) begin
            r_sclk <= 1'b0;
        end else if (tick) begin
            r_sclk <= ~r_sclk;
        end
    end

    assign rise = tick && shift_en && !r_sclk;
    assign fall = tick && shift_en && r_sclk;
    assign sclk = r_sclk;

endmodule
`default_nettype wire

// File: rtl/adc_spi_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_spi_scanner                                                      |
// | Round-robin MCP3008/MCP3208 sequencer with per-channel averaging.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module adc_spi_scanner
    import adc_pkg::*;
#(
    parameter int CLK_DIV  = 27,
    parameter int N_CH     = 8,
    parameter int ADC_BITS = 10,
    parameter int AVG_LOG2 = 2,
    parameter int GAP_CLKS = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic [N_CH-1:0]              ch_mask,
    output logic                         adc_sclk,
    output logic                         adc_cs_n,
    output logic                         adc_din,
    input  logic                         adc_dout,
    output logic                         smp_valid,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] smp_ch,
    output logic [ADC_BITS-1:0]          smp_data,
    output logic [N_CH*ADC_BITS-1:0]     result,
    output logic [N_CH-1:0]              result_vld,
    output logic                         scan_done
);

    localparam int c_CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int c_FRAME  = frame_clks(ADC_BITS);
    localparam int c_PER_W  = $clog2(c_FRAME + 1);
    localparam int c_GAP_W  = $clog2(2 * GAP_CLKS);
    localparam int c_ACC_W  = ADC_BITS + AVG_LOG2;
    localparam int c_CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [c_PER_W-1:0] c_PER_LAST = c_PER_W'(c_FRAME);
    localparam logic [c_PER_W-1:0] c_PER_NULL = c_PER_W'(CMD_CLKS + NULL_CLKS);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(2 * GAP_CLKS - 1);

    scan_state_t r_state, w_next;

    logic w_tick, w_rise, w_fall, w_sclk;
    logic w_go, w_start, w_capture, w_deliver, w_wrap, w_more;
    logic w_found_hi, w_cmd_bit;

    logic [c_CH_W-1:0]   r_ch, w_pick, w_pick_hi, w_pick_lo;
    logic [2:0]          w_ch3;
    logic [N_CH-1:0]     r_mask;
    logic [c_PER_W-1:0]  r_per, w_per_nx;
    logic [c_GAP_W-1:0]  r_gap;
    logic [ADC_BITS-1:0] r_shreg, w_sample;
    logic [c_ACC_W-1:0]  w_sum;
    logic                r_cs_n, r_din;

    logic [c_ACC_W-1:0]  r_acc [N_CH];
    logic [c_CNT_W-1:0]  r_cnt [N_CH];

    logic                     r_smp_valid, r_scan_done;
    logic [c_CH_W-1:0]        r_smp_ch;
    logic [ADC_BITS-1:0]      r_smp_data;
    logic [N_CH*ADC_BITS-1:0] r_result;
    logic [N_CH-1:0]          r_result_vld;

    adc_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (r_state != IDLE),
        .shift_en (r_state == SHIFT),
        .tick     (w_tick),
        .rise     (w_rise),
        .fall     (w_fall),
        .sclk     (w_sclk)
    );

    assign w_go    = enable && (ch_mask != '0);
    assign w_start = (w_next == SETUP) && (r_state != SETUP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_go) w_next = SETUP;
            SETUP:   if (w_tick) w_next = SHIFT;
            SHIFT:   if (w_fall && (r_per == c_PER_LAST)) w_next = GAP;
            GAP:     if (w_tick && (r_gap == c_GAP_LAST)) w_next = w_go ? SETUP : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Next set bit above the last served channel, else wrap to the lowest set bit
    always_comb begin
        w_found_hi = 1'b0;
        w_pick_hi  = '0;
        w_pick_lo  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                w_pick_lo = c_CH_W'(i);
                if (i > int'(r_ch)) begin
                    w_pick_hi  = c_CH_W'(i);
                    w_found_hi = 1'b1;
                end
            end
        end
        w_pick = w_found_hi ? w_pick_hi : w_pick_lo;
    end

    always_comb begin
        w_more = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_mask[i] && (i > int'(r_ch))) w_more = 1'b1;
        end
    end

    // Command bit presented for the upcoming SCLK period: start, SGL, D2..D0, then zeros
    assign w_per_nx = r_per + 1'b1;
    assign w_ch3    = 3'(r_ch);
    always_comb begin
        w_cmd_bit = 1'b0;
        case (int'(w_per_nx))
            1, 2:    w_cmd_bit = 1'b1;
            3:       w_cmd_bit = w_ch3[2];
            4:       w_cmd_bit = w_ch3[1];
            5:       w_cmd_bit = w_ch3[0];
            default: w_cmd_bit = 1'b0;
        endcase
    end

    assign w_capture = (r_state == SHIFT) && w_rise && (w_per_nx > c_PER_NULL);
    assign w_deliver = (r_state == SHIFT) && w_rise && (w_per_nx == c_PER_LAST);
    assign w_sample  = {r_shreg[ADC_BITS-2:0], adc_dout};
    assign w_sum     = r_acc[r_ch] + c_ACC_W'(w_sample);
    assign w_wrap    = (AVG_LOG2 == 0) || (r_cnt[r_ch] == '1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ch         <= c_CH_W'(N_CH - 1);
            r_mask       <= '0;
            r_per        <= '0;
            r_gap        <= '0;
            r_shreg      <= '0;
            r_cs_n       <= 1'b1;
            r_din        <= 1'b0;
            r_smp_valid  <= 1'b0;
            r_scan_done  <= 1'b0;
            r_smp_ch     <= '0;
            r_smp_data   <= '0;
            r_result     <= '0;
            r_result_vld <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            r_smp_valid <= 1'b0;
            r_scan_done <= 1'b0;

            if (w_start) begin
                r_ch   <= w_pick;
                r_mask <= ch_mask;
                r_cs_n <= 1'b0;
                r_din  <= 1'b1;
                r_per  <= '0;
            end

            if ((r_state == SHIFT) && w_rise) begin
                r_per <= w_per_nx;
                if (w_capture) r_shreg <= w_sample;
            end

            if ((r_state == SHIFT) && w_fall) begin
                if (r_per == c_PER_LAST) begin
                    r_cs_n <= 1'b1;
                    r_din  <= 1'b0;
                    r_gap  <= '0;
                end else begin
                    r_din <= w_cmd_bit;
                end
            end

            if ((r_state == GAP) && w_tick) r_gap <= r_gap + 1'b1;

            if (w_deliver) begin
                r_smp_valid <= 1'b1;
                r_smp_ch    <= r_ch;
                r_smp_data  <= w_sample;
                r_scan_done <= !w_more;
                if (w_wrap) begin
                    r_acc[r_ch] <= '0;
                    r_cnt[r_ch] <= '0;
                    r_result[r_ch*ADC_BITS +: ADC_BITS] <= ADC_BITS'(w_sum >> AVG_LOG2);
                    r_result_vld[r_ch] <= 1'b1;
                end else begin
                    r_acc[r_ch] <= w_sum;
                    r_cnt[r_ch] <= r_cnt[r_ch] + 1'b1;
                end
            end
        end
    end

    assign adc_sclk   = w_sclk;
    assign adc_cs_n   = r_cs_n;
    assign adc_din    = r_din;
    assign smp_valid  = r_smp_valid;
    assign smp_ch     = r_smp_ch;
    assign smp_data   = r_smp_data;
    assign result     = r_result;
    assign result_vld = r_result_vld;
    assign scan_done  = r_scan_done;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adc_spi_scanner                                                   |
// | Directed bench with MCP3008 / MCP3208 behavioural converter models.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_adc_spi_scanner;

    localparam int c_PERIOD_A = 74;   // (1 + 2*(16+2)) * 2

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- DUT A: 10-bit, 4-sample averaging ----------------
    logic       en_a = 1'b0;
    logic [7:0] mask_a = 8'h00;
    logic       sclk_a, cs_a, din_a, sv_a, done_a;
    logic       dout_a = 1'b0;
    logic [2:0] sch_a;
    logic [9:0] sdat_a;
    logic [79:0] res_a;
    logic [7:0] vld_a;

    adc_spi_scanner #(.CLK_DIV(2), .N_CH(8), .ADC_BITS(10), .AVG_LOG2(2), .GAP_CLKS(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .ch_mask(mask_a),
        .adc_sclk(sclk_a), .adc_cs_n(cs_a), .adc_din(din_a), .adc_dout(dout_a),
        .smp_valid(sv_a), .smp_ch(sch_a), .smp_data(sdat_a),
        .result(res_a), .result_vld(vld_a), .scan_done(done_a)
    );

    // ---------------- DUT B: 12-bit, no averaging ----------------
    logic       en_b = 1'b0;
    logic [7:0] mask_b = 8'h00;
    logic       sclk_b, cs_b, din_b, sv_b, done_b;
    logic       dout_b = 1'b0;
    logic [2:0] sch_b;
    logic [11:0] sdat_b;
    logic [95:0] res_b;
    logic [7:0] vld_b;

    adc_spi_scanner #(.CLK_DIV(2), .N_CH(8), .ADC_BITS(12), .AVG_LOG2(0), .GAP_CLKS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .ch_mask(mask_b),
        .adc_sclk(sclk_b), .adc_cs_n(cs_b), .adc_din(din_b), .adc_dout(dout_b),
        .smp_valid(sv_b), .smp_ch(sch_b), .smp_data(sdat_b),
        .result(res_b), .result_vld(vld_b), .scan_done(done_b)
    );

    // ---------------- MCP3008 model for A ----------------
    int         bc_a = 0, len_a = 0, rise_a = 0, cs_low_a = 0, ramp_k = 0;
    bit         ramp = 1'b0;
    logic [4:0] cmd_a = '0, last_cmd_a = '0;
    logic [9:0] val_a = '0;
    logic [9:0] ch_val_a [8];

    always @(negedge cs_a) begin bc_a = 0; cmd_a = '0; dout_a = 1'b0; end
    always @(posedge cs_a) len_a = bc_a;
    always @(posedge clk) if (!cs_a) cs_low_a++;

    always @(posedge sclk_a) begin
        rise_a++;
        if (!cs_a) begin
            bc_a++;
            if (bc_a <= 5) cmd_a = {cmd_a[3:0], din_a};
            if (bc_a == 5) last_cmd_a = cmd_a;
        end
    end

    always @(negedge sclk_a) begin
        if (!cs_a) begin
            if (bc_a == 5) begin
                if (ramp && cmd_a[2:0] == 3'd1) begin
                    val_a = 10'(100 + ramp_k);
                    ramp_k++;
                end else begin
                    val_a = ch_val_a[cmd_a[2:0]];
                end
                dout_a = 1'b0;
            end else if (bc_a >= 6 && bc_a - 6 < 10) begin
                dout_a = val_a[9 - (bc_a - 6)];
            end else begin
                dout_a = 1'b0;
            end
        end
    end

    // ---------------- MCP3208 model for B (always full scale) ----------------
    int          bc_b = 0, len_b = 0;
    logic [4:0]  cmd_b = '0, last_cmd_b = '0;
    logic [11:0] val_b = 12'hFFF;

    always @(negedge cs_b) begin bc_b = 0; cmd_b = '0; dout_b = 1'b0; end
    always @(posedge cs_b) len_b = bc_b;

    always @(posedge sclk_b) begin
        if (!cs_b) begin
            bc_b++;
            if (bc_b <= 5) cmd_b = {cmd_b[3:0], din_b};
            if (bc_b == 5) last_cmd_b = cmd_b;
        end
    end

    always @(negedge sclk_b) begin
        if (!cs_b) begin
            if (bc_b >= 6 && bc_b - 6 < 12) dout_b = val_b[11 - (bc_b - 6)];
            else dout_b = 1'b0;
        end
    end

    // ---------------- sample monitors ----------------
    typedef struct {
        int         cyc;
        logic [2:0] ch;
        logic [11:0] dat;
        logic       done;
        logic [4:0] cmd;
    } smp_t;

    smp_t q_a[$];
    smp_t q_b[$];

    always @(negedge clk) begin
        if (sv_a) q_a.push_back('{cyc, sch_a, {2'b00, sdat_a}, done_a, last_cmd_a});
        if (sv_b) q_b.push_back('{cyc, sch_b, sdat_b, done_b, last_cmd_b});
    end

    // ---------------- checking helpers ----------------
    int n_app = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_app++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_a(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            if (q_a.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_app++;
            n_bad++;
            $display("FAIL timeout: no sample within %0d clks", n);
        end
    endtask

    task automatic wait_bc(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!cs_a && bc_a == target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_app++;
            n_bad++;
            $display("FAIL timeout: SCLK period %0d never reached", target);
        end
    endtask

    typedef struct {
        logic [2:0] ch;
        logic [9:0] dat;
        logic       done;
        logic [4:0] cmd;
        logic       vld;
        logic [9:0] res;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        smp_t e;
        bit   ok;
        int   prev, r0, c0;

        tbl[0] = '{3'd0, 10'h2AA, 1'b0, 5'b11000, 1'b0, 10'h000};
        tbl[1] = '{3'd5, 10'h155, 1'b1, 5'b11101, 1'b0, 10'h000};
        tbl[2] = '{3'd0, 10'h2AA, 1'b0, 5'b11000, 1'b0, 10'h000};
        tbl[3] = '{3'd5, 10'h155, 1'b1, 5'b11101, 1'b0, 10'h000};
        tbl[4] = '{3'd0, 10'h2AA, 1'b0, 5'b11000, 1'b0, 10'h000};
        tbl[5] = '{3'd5, 10'h155, 1'b1, 5'b11101, 1'b0, 10'h000};
        tbl[6] = '{3'd0, 10'h2AA, 1'b0, 5'b11000, 1'b1, 10'h2AA};
        tbl[7] = '{3'd5, 10'h155, 1'b1, 5'b11101, 1'b1, 10'h155};

        for (int i = 0; i < 8; i++) ch_val_a[i] = 10'h100 + 10'(i);
        ch_val_a[0] = 10'h2AA;
        ch_val_a[5] = 10'h155;

        // reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst cs_n", cs_a, 1);
        chk("rst sclk", sclk_a, 0);
        chk("rst din", din_a, 0);
        chk("rst smp_valid", sv_a, 0);
        chk("rst result", res_a, 0);
        chk("rst result_vld", vld_a, 0);
        chk("rst scan_done", done_a, 0);
        rst_n = 1'b1;

        // round-robin over mask 0x21 with averaging
        mask_a = 8'h21; en_a = 1'b1;
        mask_b = 8'h80; en_b = 1'b1;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            wait_a(400, ok);
            if (ok) begin
                e = q_a.pop_front();
                chk($sformatf("v%0d ch", i), e.ch, tbl[i].ch);
                chk($sformatf("v%0d data", i), e.dat, tbl[i].dat);
                chk($sformatf("v%0d scan_done", i), e.done, tbl[i].done);
                chk($sformatf("v%0d din cmd", i), e.cmd, tbl[i].cmd);
                chk($sformatf("v%0d result_vld", i), vld_a[tbl[i].ch], tbl[i].vld);
                chk($sformatf("v%0d result", i), res_a[int'(tbl[i].ch)*10 +: 10], tbl[i].res);
                if (i > 0) chk($sformatf("v%0d frame period", i), e.cyc - prev, c_PERIOD_A);
                prev = e.cyc;
            end
        end

        // 12-bit converter on channel 7
        en_b = 1'b0;
        chk("B has sample", q_b.size() > 0, 1);
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            chk("B ch", e.ch, 7);
            chk("B data", e.dat, 12'hFFF);
            chk("B scan_done", e.done, 1);
            chk("B din cmd", e.cmd, 5'b11111);
            chk("B frame sclk periods", len_b, 18);
            chk("B result", res_b[84 +: 12], 12'hFFF);
            chk("B result_vld", vld_b, 8'h80);
        end

        // averaging of 100..103 on channel 1
        en_a = 1'b0;
        repeat (200) @(posedge clk);
        q_a.delete();
        ramp = 1'b1; ramp_k = 0;
        mask_a = 8'h02; en_a = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_a(400, ok);
            if (ok) begin
                e = q_a.pop_front();
                chk($sformatf("avg%0d ch", k), e.ch, 1);
                chk($sformatf("avg%0d data", k), e.dat, 100 + k);
                chk($sformatf("avg%0d scan_done", k), e.done, 1);
                chk($sformatf("avg%0d din cmd", k), e.cmd, 5'b11001);
                chk($sformatf("avg%0d result", k), res_a[10 +: 10], (k == 3) ? 101 : 0);
                chk($sformatf("avg%0d result_vld", k), vld_a[1], (k == 3) ? 1 : 0);
            end
        end
        en_a = 1'b0;
        ramp = 1'b0;
        repeat (200) @(posedge clk);

        // enable dropped at SCLK period 4
        q_a.delete();
        mask_a = 8'h01; en_a = 1'b1;
        wait_bc(4, ok);
        en_a = 1'b0;
        r0 = rise_a;
        repeat (300) @(posedge clk);
        #1;
        chk("drop sample count", q_a.size(), 1);
        if (q_a.size() > 0) chk("drop ch", q_a[0].ch, 0);
        chk("drop remaining sclk rises", rise_a - r0, 12);
        chk("drop cs_n", cs_a, 1);
        chk("drop frame periods", len_a, 16);

        // empty mask keeps bus idle
        q_a.delete();
        mask_a = 8'h00; en_a = 1'b1;
        r0 = rise_a; c0 = cs_low_a;
        repeat (150) @(posedge clk);
        chk("mask0 sclk rises", rise_a - r0, 0);
        chk("mask0 cs_n low clks", cs_low_a - c0, 0);
        mask_a = 8'h04;
        wait_a(400, ok);
        if (ok) begin
            e = q_a.pop_front();
            chk("mask4 ch", e.ch, 2);
            chk("mask4 din cmd", e.cmd, 5'b11010);
        end
        mask_a = 8'h00;
        repeat (200) @(posedge clk);
        #1;
        chk("mask->0 no more samples", q_a.size(), 0);
        chk("mask->0 cs_n", cs_a, 1);

        // mask change sampled in GAP
        mask_a = 8'h01;
        wait_a(400, ok);
        if (ok) begin
            e = q_a.pop_front();
            chk("gap pre ch", e.ch, 0);
            prev = e.cyc;
            mask_a = 8'h04;
            wait_a(400, ok);
            if (ok) begin
                e = q_a.pop_front();
                chk("gap post ch", e.ch, 2);
                chk("gap post period", e.cyc - prev, c_PERIOD_A);
            end
        end

        // reset mid-frame
        mask_a = 8'hFF;
        wait_bc(10, ok);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst cs_n", cs_a, 1);
        chk("midrst sclk", sclk_a, 0);
        chk("midrst result_vld", vld_a, 0);
        chk("midrst result", res_a, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q_a.delete();
        wait_a(400, ok);
        if (ok) begin
            e = q_a.pop_front();
            chk("post-rst ch", e.ch, 0);
            chk("post-rst din cmd", e.cmd, 5'b11000);
            chk("post-rst data", e.dat, 10'h2AA);
        end
        en_a = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_app, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
